// File: rtl/axi2mem_rd_channel_if.sv
// Bundle of the AR, memory-read and R signals around the read-channel engine.
// The slave modport is the engine's view; the master modport is the view of
// the surrounding AR buffer, memory and R consumer.
interface axi2mem_rd_channel_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int USER_WIDTH = 6,
    parameter int DATA_WIDTH = 64
) ();
    logic                  ar_valid_i;
    logic [ADDR_WIDTH-1:0] ar_addr_i;
    logic [7:0]            ar_len_i;
    logic [2:0]            ar_size_i;
    logic [1:0]            ar_burst_i;
    logic                  ar_lock_i;
    logic [ID_WIDTH-1:0]   ar_id_i;
    logic [USER_WIDTH-1:0] ar_user_i;
    logic                  ar_ready_o;

    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_add_o;
    logic                  mem_gnt_i;
    logic                  mem_r_valid_i;
    logic [DATA_WIDTH-1:0] mem_r_rdata_i;

    logic                  r_valid_o;
    logic [DATA_WIDTH-1:0] r_data_o;
    logic [1:0]            r_resp_o;
    logic                  r_last_o;
    logic [ID_WIDTH-1:0]   r_id_o;
    logic [USER_WIDTH-1:0] r_user_o;
    logic                  r_ready_i;

    modport slave (
        input  ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i,
               ar_lock_i, ar_id_i, ar_user_i,
        output ar_ready_o,
        output mem_req_o, mem_add_o,
        input  mem_gnt_i, mem_r_valid_i, mem_r_rdata_i,
        output r_valid_o, r_data_o, r_resp_o, r_last_o, r_id_o, r_user_o,
        input  r_ready_i
    );

    modport master (
        output ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i,
               ar_lock_i, ar_id_i, ar_user_i,
        input  ar_ready_o,
        input  mem_req_o, mem_add_o,
        output mem_gnt_i, mem_r_valid_i, mem_r_rdata_i,
        input  r_valid_o, r_data_o, r_resp_o, r_last_o, r_id_o, r_user_o,
        output r_ready_i
    );
endinterface

// File: rtl/axi2mem_rd_channel.sv
// AXI read-channel engine: takes one AR burst at a time, issues one memory
// read per beat (FIXED / INCR / WRAP addressing) and returns the data on R
// through a 2-entry FIFO. A credit rule (outstanding + queued < 2) keeps the
// FIFO from overflowing under R backpressure.
// Optional feature: define AXI2MEM_RD_EXCL_EN to return EXOKAY on locked bursts.
module axi2mem_rd_channel #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int USER_WIDTH = 6,
    parameter int DATA_WIDTH = 64
) (
    input logic                 clk_i,
    input logic                 rst_i,
    axi2mem_rd_channel_if.slave bus
);
    localparam int              BYTE_LSB  = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0]      MAX_ES    = 3'(BYTE_LSB);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {ADDR_WIDTH{1'b1}} << BYTE_LSB;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state;
    logic                  ar_ready_q;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [7:0]            len_q;
    logic [2:0]            es_q;
    logic [1:0]            burst_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [USER_WIDTH-1:0] user_q;
    logic [8:0]            req_left;
    logic [8:0]            beat_left;
    logic [1:0]            outstanding;

    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_count;

    logic                  mem_req;
    logic                  ar_fire;
    logic                  gnt_fire;
    logic                  push;
    logic                  pop;
    logic [2:0]            es_in;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic                  wrap_ok;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign mem_req  = (state == BUSY) && (req_left != 9'd0) &&
                      (({1'b0, outstanding} + {1'b0, fifo_count}) < 3'd2);
    assign ar_fire  = ar_ready_q & bus.ar_valid_i;
    assign gnt_fire = mem_req & bus.mem_gnt_i;
    assign push     = bus.mem_r_valid_i;
    assign pop      = (fifo_count != 2'd0) & bus.r_ready_i;
    assign es_in    = (bus.ar_size_i > MAX_ES) ? MAX_ES : bus.ar_size_i;

    // Next beat address: FIXED stays put, WRAP folds inside the wrap window, all else increments.
    always_comb begin
        step      = ADDR_WIDTH'(1) << es_q;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << es_q) - ADDR_WIDTH'(1);
        wrap_ok   = (burst_q == 2'b10) &&
                    ((len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15));
        next_addr = cur_addr + step;
        if (burst_q == 2'b00) begin
            next_addr = cur_addr;
        end else if (wrap_ok) begin
            next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + step) & wrap_mask);
        end
    end

    // Burst FSM: accept one AR, walk the request addresses, count beats back out on R.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ar_ready_q <= 1'b0;
            cur_addr   <= '0;
            len_q      <= '0;
            es_q       <= '0;
            burst_q    <= '0;
            id_q       <= '0;
            user_q     <= '0;
            req_left   <= '0;
            beat_left  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ar_ready_q <= 1'b1;
                    if (ar_fire) begin
                        cur_addr   <= bus.ar_addr_i;
                        len_q      <= bus.ar_len_i;
                        es_q       <= es_in;
                        burst_q    <= bus.ar_burst_i;
                        id_q       <= bus.ar_id_i;
                        user_q     <= bus.ar_user_i;
                        req_left   <= {1'b0, bus.ar_len_i} + 9'd1;
                        beat_left  <= {1'b0, bus.ar_len_i} + 9'd1;
                        ar_ready_q <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (gnt_fire) begin
                        req_left <= req_left - 9'd1;
                        cur_addr <= next_addr;
                    end
                    if (pop) begin
                        beat_left <= beat_left - 9'd1;
                        if (beat_left == 9'd1) begin
                            state      <= IDLE;
                            ar_ready_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beats granted by memory whose data has not come back yet.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding <= '0;
        end else begin
            case ({gnt_fire, push})
                2'b10:   outstanding <= outstanding + 2'd1;
                2'b01:   outstanding <= outstanding - 2'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Two-entry response FIFO; simultaneous push and pop keep the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.mem_r_rdata_i;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef AXI2MEM_RD_EXCL_EN
    logic lock_q;

    // Remember whether the current burst is exclusive so each beat can report EXOKAY.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q <= 1'b0;
        end else if (ar_fire) begin
            lock_q <= bus.ar_lock_i;
        end
    end

    assign bus.r_resp_o = {1'b0, lock_q};
`else
    assign bus.r_resp_o = 2'b00;
`endif

    assign bus.ar_ready_o = ar_ready_q;
    assign bus.mem_req_o  = mem_req;
    assign bus.mem_add_o  = cur_addr & WORD_MASK;
    assign bus.r_valid_o  = (fifo_count != 2'd0);
    assign bus.r_data_o   = fifo_mem[rd_ptr];
    assign bus.r_last_o   = (beat_left == 9'd1);
    assign bus.r_id_o     = id_q;
    assign bus.r_user_o   = user_q;

endmodule

// File: tb/tb_axi2mem_rd_channel.sv
// Directed testbench for axi2mem_rd_channel: a one-cycle-latency memory model,
// expected address lists per burst and an R scoreboard built from them.
module tb_axi2mem_rd_channel;
    localparam int ID_WIDTH   = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int USER_WIDTH = 6;
    localparam int DATA_WIDTH = 64;

    logic clk;
    logic rst;

    axi2mem_rd_channel_if #(
        .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .USER_WIDTH(USER_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) bus ();

    axi2mem_rd_channel #(
        .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .USER_WIDTH(USER_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int errors;
    int checks;
    int cyc;
    int seq;
    int beats_seen;
    int grants;
    int cur_len;
    int ar_cyc;
    int first_valid_cyc;
    bit seen_valid;
    logic [ID_WIDTH-1:0]   cur_id;
    logic [USER_WIDTH-1:0] cur_user;
    logic [1:0]            cur_resp;
    logic [31:0]           exp_addr_q[$];
    logic [63:0]           exp_data_q[$];
    logic                  pend_valid;
    logic [63:0]           pend_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Memory model (data one cycle after grant) plus grant and R scoreboards.
    always @(negedge clk) begin
        logic [31:0] ea;
        logic [63:0] ed;
        if (rst) begin
            bus.mem_r_valid_i = 1'b0;
            pend_valid        = 1'b0;
        end else begin
            bus.mem_r_valid_i = pend_valid;
            bus.mem_r_rdata_i = pend_data;
            pend_valid        = 1'b0;
            if (bus.mem_req_o && bus.mem_gnt_i) begin
                pend_valid = 1'b1;
                pend_data  = {bus.mem_add_o, seq[31:0]};
                if (exp_addr_q.size() == 0) begin
                    checkOutput("extra_grant", 1, 0);
                end else begin
                    ea = exp_addr_q.pop_front();
                    checkOutput("mem_add", bus.mem_add_o, ea);
                    exp_data_q.push_back({ea, seq[31:0]});
                end
                seq++;
                grants++;
            end
            if (bus.r_valid_o && !seen_valid) begin
                seen_valid      = 1'b1;
                first_valid_cyc = cyc;
            end
            if (bus.r_valid_o && bus.r_ready_i) begin
                if (exp_data_q.size() == 0) begin
                    checkOutput("extra_beat", 1, 0);
                end else begin
                    ed = exp_data_q.pop_front();
                    checkOutput("r_data", bus.r_data_o, ed);
                end
                checkOutput("r_id", bus.r_id_o, cur_id);
                checkOutput("r_user", bus.r_user_o, cur_user);
                checkOutput("r_resp", bus.r_resp_o, cur_resp);
                checkOutput("r_last", bus.r_last_o, (beats_seen == cur_len) ? 1'b1 : 1'b0);
                beats_seen++;
            end
        end
    end

    // Issue one AR and wait (bounded) for its handshake.
    task automatic applyStimulus(input logic [31:0] addr, input int len, input logic [2:0] size,
                                 input logic [1:0] burst, input logic lock,
                                 input logic [3:0] id, input logic [5:0] user);
        bit got;
        cur_len    = len;
        cur_id     = id;
        cur_user   = user;
`ifdef AXI2MEM_RD_EXCL_EN
        cur_resp   = lock ? 2'b01 : 2'b00;
`else
        cur_resp   = 2'b00;
`endif
        beats_seen = 0;
        grants     = 0;
        seen_valid = 1'b0;
        got        = 1'b0;
        @(posedge clk);
        #1;
        bus.ar_valid_i = 1'b1;
        bus.ar_addr_i  = addr;
        bus.ar_len_i   = 8'(len);
        bus.ar_size_i  = size;
        bus.ar_burst_i = burst;
        bus.ar_lock_i  = lock;
        bus.ar_id_i    = id;
        bus.ar_user_i  = user;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.ar_ready_o) begin
                ar_cyc = cyc;
                got    = 1'b1;
                break;
            end
        end
        if (!got) checkOutput("ar_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.ar_valid_i = 1'b0;
    endtask

    // Wait (bounded) for all beats, then expect ar_ready back the following cycle.
    task automatic waitDone(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            if (beats_seen == cur_len + 1) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) checkOutput({tag, "_timeout"}, beats_seen, cur_len + 1);
        @(negedge clk);
        checkOutput({tag, "_ar_ready_after"}, bus.ar_ready_o, 1);
        checkOutput({tag, "_leftover"}, exp_addr_q.size() + exp_data_q.size(), 0);
    endtask

    task automatic checkZeros(input string tag);
        checkOutput({tag, "_ar_ready"}, bus.ar_ready_o, 0);
        checkOutput({tag, "_mem_req"}, bus.mem_req_o, 0);
        checkOutput({tag, "_r_valid"}, bus.r_valid_o, 0);
        checkOutput({tag, "_r_last"}, bus.r_last_o, 0);
        checkOutput({tag, "_busses"},
                    {bus.mem_add_o, bus.r_data_o, bus.r_id_o, bus.r_user_o, bus.r_resp_o}, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        errors = 0; checks = 0; cyc = 0; seq = 0;
        beats_seen = 0; grants = 0; cur_len = 0; seen_valid = 1'b0;
        cur_id = '0; cur_user = '0; cur_resp = '0;
        pend_valid = 1'b0; pend_data = '0;
        rst = 1'b1;
        bus.ar_valid_i = 1'b0; bus.ar_addr_i = '0; bus.ar_len_i = '0; bus.ar_size_i = '0;
        bus.ar_burst_i = '0; bus.ar_lock_i = 1'b0; bus.ar_id_i = '0; bus.ar_user_i = '0;
        bus.mem_gnt_i = 1'b1; bus.mem_r_valid_i = 1'b0; bus.mem_r_rdata_i = '0;
        bus.r_ready_i = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkZeros("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("ar_ready_post_reset", bus.ar_ready_o, 1);

        // 1: INCR 0x100 len3 size3 id5, latency and ar_ready return
        $display("[TB] test 1 INCR");
        exp_addr_q = '{32'h100, 32'h108, 32'h110, 32'h118};
        applyStimulus(32'h100, 3, 3'd3, 2'b01, 1'b0, 4'h5, 6'h11);
        waitDone("t1");
        checkOutput("t1_latency", first_valid_cyc - ar_cyc, 3);

        // 2: WRAP 0x118 len3 size3
        $display("[TB] test 2 WRAP");
        exp_addr_q = '{32'h118, 32'h100, 32'h108, 32'h110};
        applyStimulus(32'h118, 3, 3'd3, 2'b10, 1'b0, 4'h2, 6'h03);
        waitDone("t2");

        // 3: FIXED 0x40 len2
        $display("[TB] test 3 FIXED");
        exp_addr_q = '{32'h40, 32'h40, 32'h40};
        applyStimulus(32'h40, 2, 3'd3, 2'b00, 1'b0, 4'h7, 6'h3F);
        waitDone("t3");

        // 4: INCR len7 with R backpressure
        $display("[TB] test 4 backpressure");
        exp_addr_q = '{32'h1000, 32'h1008, 32'h1010, 32'h1018,
                       32'h1020, 32'h1028, 32'h1030, 32'h1038};
        bus.r_ready_i = 1'b0;
        applyStimulus(32'h1000, 7, 3'd3, 2'b01, 1'b0, 4'h9, 6'h05);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("t4_grants_held", grants, 2);
        checkOutput("t4_mem_req_off", bus.mem_req_o, 0);
        checkOutput("t4_r_valid", bus.r_valid_o, 1);
        @(posedge clk);
        #1 bus.r_ready_i = 1'b1;
        waitDone("t4");
        checkOutput("t4_beats", beats_seen, 8);

        // 5: grant withheld for 5 cycles mid-burst
        $display("[TB] test 5 grant stall");
        exp_addr_q = '{32'h200, 32'h208, 32'h210, 32'h218};
        applyStimulus(32'h200, 3, 3'd3, 2'b01, 1'b0, 4'h3, 6'h00);
        @(posedge clk);
        #1 bus.mem_gnt_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("t5_req_hold", bus.mem_req_o, 1);
            checkOutput("t5_addr_hold", bus.mem_add_o, 32'h208);
        end
        @(posedge clk);
        #1 bus.mem_gnt_i = 1'b1;
        waitDone("t5");

        // 7: narrow INCR (size 2) crossing word boundaries
        $display("[TB] test 7 narrow INCR");
        exp_addr_q = '{32'h0, 32'h8, 32'h8, 32'h10};
        applyStimulus(32'h4, 3, 3'd2, 2'b01, 1'b0, 4'h1, 6'h01);
        waitDone("t7");

        // 8: WRAP with len 2 behaves as INCR; oversize clamps to the bus width
        $display("[TB] test 8 WRAP len2 / size clamp");
        exp_addr_q = '{32'h118, 32'h120, 32'h128};
        applyStimulus(32'h118, 2, 3'd6, 2'b10, 1'b0, 4'h4, 6'h02);
        waitDone("t8");

        // 6: reset after beat 2 of len7, then a fresh (locked) burst
        $display("[TB] test 6 reset mid-burst");
        exp_addr_q = '{32'h2000, 32'h2008, 32'h2010, 32'h2018,
                       32'h2020, 32'h2028, 32'h2030, 32'h2038};
        applyStimulus(32'h2000, 7, 3'd3, 2'b01, 1'b0, 4'h6, 6'h06);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (beats_seen >= 2) break;
        end
        checkOutput("t6_two_beats", (beats_seen >= 2) ? 1 : 0, 1);
        #1 rst = 1'b1;
        @(posedge clk);
        exp_addr_q.delete();
        exp_data_q.delete();
        #1 rst = 1'b0;
        @(negedge clk);
        checkZeros("t6_after_reset");
        @(negedge clk);
        checkOutput("t6_ar_ready", bus.ar_ready_o, 1);
        exp_addr_q = '{32'h300, 32'h308, 32'h310, 32'h318};
        applyStimulus(32'h300, 3, 3'd3, 2'b01, 1'b1, 4'hA, 6'h2A);
        waitDone("t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
